// File: rtl/midi_note_tx.sv
// MIDI OUT transmitter: serializes a note-on/off request as {status, D1, D2} UART bytes (8N1).
// Optional RUNNING_STATUS_EN omits the status byte when it repeats the last completed message.
module midi_note_tx #(
    parameter int CLKS_PER_BIT = 1600
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req,
    input  logic       note_on,
    input  logic [3:0] ch,
    input  logic [6:0] D1,
    input  logic [6:0] D2,
    output logic       ready,
    output logic       tx,
    output logic       byte_done,
    output logic       msg_done
);

    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, SEND_STATUS, SEND_D1, SEND_D2} msg_state_t;
    // ARM is the single mark cycle between acceptance and the first start bit
    typedef enum logic [1:0] {ARM, START, DATA, STOP} bit_state_t;

    msg_state_t state, state_nxt;
    bit_state_t sub, sub_nxt;
    logic [BW-1:0] baud, baud_nxt;
    logic [2:0]    bit_idx, bit_nxt;
    logic [7:0]    cap_status;
    logic [6:0]    cap_d1, cap_d2;
    logic [7:0]    req_status, cur_byte;
    logic          accept, skip_status, baud_wrap;
    logic          tx_nxt, byte_done_nxt, msg_done_nxt;

    assign req_status = {1'b1, 2'b00, note_on, ch};
    assign ready      = (state == IDLE);
    assign accept     = req && ready;
    assign baud_wrap  = (baud == BAUD_MAX);

`ifdef RUNNING_STATUS_EN
    logic [7:0] last_status;
    logic       last_valid;

    assign skip_status = last_valid && (req_status == last_status);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_status <= 8'h00;
            last_valid  <= 1'b0;
        end else if (msg_done_nxt) begin
            last_status <= cap_status;
            last_valid  <= 1'b1;
        end
    end
`else
    assign skip_status = 1'b0;
`endif

    always_comb begin
        state_nxt     = state;
        sub_nxt       = sub;
        baud_nxt      = baud;
        bit_nxt       = bit_idx;
        byte_done_nxt = 1'b0;
        msg_done_nxt  = 1'b0;
        if (state == IDLE) begin
            if (req) begin
                state_nxt = skip_status ? SEND_D1 : SEND_STATUS;
                sub_nxt   = ARM;
                baud_nxt  = '0;
                bit_nxt   = '0;
            end
        end else begin
            case (sub)
                ARM: sub_nxt = START;
                START: begin
                    if (baud_wrap) begin
                        baud_nxt = '0;
                        sub_nxt  = DATA;
                    end else begin
                        baud_nxt = baud + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_wrap) begin
                        baud_nxt = '0;
                        bit_nxt  = bit_idx + 3'd1;
                        if (bit_idx == 3'd7) sub_nxt = STOP;
                    end else begin
                        baud_nxt = baud + 1'b1;
                    end
                end
                STOP: begin
                    if (baud_wrap) begin
                        baud_nxt      = '0;
                        byte_done_nxt = 1'b1;
                        sub_nxt       = START;  // next byte starts with no idle gap
                        case (state)
                            SEND_STATUS: state_nxt = SEND_D1;
                            SEND_D1:     state_nxt = SEND_D2;
                            default: begin
                                state_nxt    = IDLE;
                                sub_nxt      = ARM;
                                msg_done_nxt = 1'b1;
                            end
                        endcase
                    end else begin
                        baud_nxt = baud + 1'b1;
                    end
                end
                default: sub_nxt = ARM;
            endcase
        end
    end

    // tx is registered from next-state so the pin never glitches
    always_comb begin
        cur_byte = 8'hFF;
        case (state_nxt)
            SEND_STATUS: cur_byte = cap_status;
            SEND_D1:     cur_byte = {1'b0, cap_d1};
            SEND_D2:     cur_byte = {1'b0, cap_d2};
            default:     cur_byte = 8'hFF;
        endcase
        tx_nxt = 1'b1;
        if (state_nxt != IDLE) begin
            case (sub_nxt)
                START:   tx_nxt = 1'b0;
                DATA:    tx_nxt = cur_byte[bit_nxt];
                default: tx_nxt = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sub       <= ARM;
            baud      <= '0;
            bit_idx   <= '0;
            tx        <= 1'b1;
            byte_done <= 1'b0;
            msg_done  <= 1'b0;
        end else begin
            state     <= state_nxt;
            sub       <= sub_nxt;
            baud      <= baud_nxt;
            bit_idx   <= bit_nxt;
            tx        <= tx_nxt;
            byte_done <= byte_done_nxt;
            msg_done  <= msg_done_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_status <= 8'h00;
            cap_d1     <= 7'h00;
            cap_d2     <= 7'h00;
        end else if (accept) begin
            cap_status <= req_status;
            cap_d1     <= D1;
            cap_d2     <= D2;
        end
    end

endmodule

// File: tb/tb_midi_note_tx.sv
// Directed bench for midi_note_tx: a line decoder pops expected bytes from a scoreboard queue.
module tb_midi_note_tx;
    localparam int CPB = 4;

    logic clk = 1'b0, rst_n = 1'b1, req = 1'b0, note_on = 1'b0;
    logic [3:0] ch = '0;
    logic [6:0] D1 = '0, D2 = '0;
    logic ready, tx, byte_done, msg_done;

    int checks = 0, errors = 0;
    int bd_cnt = 0, md_cnt = 0, rx_cnt = 0, exp_total = 0;
    logic [7:0] exp_q[$];
    logic [7:0] m_last = 8'h00;
    logic       m_valid = 1'b0;

    always #5 clk = ~clk;

    midi_note_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .note_on(note_on), .ch(ch),
        .D1(D1), .D2(D2), .ready(ready), .tx(tx), .byte_done(byte_done), .msg_done(msg_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    always @(posedge clk) begin
        if (byte_done === 1'b1) bd_cnt <= bd_cnt + 1;
        if (msg_done === 1'b1)  md_cnt <= md_cnt + 1;
    end

    // Reference model: status byte plus optional running-status elision
    function automatic int model_push(input logic on, input logic [3:0] c,
                                      input logic [6:0] d1, input logic [6:0] d2);
        logic [7:0] st;
        logic       skip;
        st   = {1'b1, 2'b00, on, c};
        skip = 1'b0;
`ifdef RUNNING_STATUS_EN
        skip = m_valid && (st == m_last);
`endif
        if (!skip) exp_q.push_back(st);
        exp_q.push_back({1'b0, d1});
        exp_q.push_back({1'b0, d2});
        m_last  = st;
        m_valid = 1'b1;
        exp_total += skip ? 2 : 3;
        return skip ? 2 : 3;
    endfunction

    // Line decoder: sampled on negedge, every bit must hold CPB samples
    initial begin : mon
        logic [7:0] b, e;
        logic ok, aborted, v;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && tx === 1'b0) begin
                ok = 1'b1; aborted = 1'b0; b = '0; v = 1'b0;
                for (int s = 1; s < 10 * CPB; s++) begin
                    @(negedge clk);
                    if (rst_n !== 1'b1) begin aborted = 1'b1; break; end
                    if (s % CPB == 0) begin
                        v = tx;
                        if (s / CPB <= 8) b[3'(s / CPB - 1)] = v;
                    end else if (tx !== v) ok = 1'b0;
                end
                if (!aborted) begin
                    if (v !== 1'b1) ok = 1'b0;
                    chk("bit_timing", ok, 1);
                    if (exp_q.size() > 0) e = exp_q.pop_front();
                    else e = 'x;
                    chk("rx_byte", b, e);
                    rx_cnt++;
                end
            end
        end
    end

    task automatic wait_ready();
        int w = 0;
        @(negedge clk);
        while (ready !== 1'b1 && w < 500) begin @(negedge clk); w++; end
        chk("ready_before_req", ready, 1);
    endtask

    task automatic drive(input logic on, input logic [3:0] c, input logic [6:0] d1, input logic [6:0] d2);
        note_on = on; ch = c; D1 = d1; D2 = d2; req = 1'b1;
    endtask

    // inj >= 0 asserts a stray request with junk fields that many cycles after tx falls
    task automatic send(input logic on, input logic [3:0] c, input logic [6:0] d1,
                        input logic [6:0] d2, input int inj);
        int nb, bd0, md0, n;
        wait_ready();
        nb = model_push(on, c, d1, d2);
        bd0 = bd_cnt; md0 = md_cnt;
        drive(on, c, d1, d2);
        @(posedge clk); #1 req = 1'b0;
        @(negedge clk);
        chk("arm_tx_high", tx, 1);
        chk("ready_fall", ready, 0);
        @(negedge clk);
        chk("tx_fall_latency", tx, 0);
        n = 1;
        while (ready !== 1'b1 && n < 2000) begin
            @(negedge clk);
            if (n == inj) begin note_on = 1'b0; ch = 4'hF; D1 = 7'h7F; D2 = 7'h7F; req = 1'b1; end
            if (n == inj + 3) req = 1'b0;
            if (ready !== 1'b1) n++;
        end
        chk("msg_cycles", n, nb * 10 * CPB);
        @(posedge clk); #1;
        chk("byte_done_pulses", bd_cnt - bd0, nb);
        chk("msg_done_pulses", md_cnt - md0, 1);
        chk("queue_drained", exp_q.size(), 0);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin : stim
        int nb, w, mdn, cyc, gap;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tx", tx, 1);
        chk("rst_ready", ready, 1);
        chk("rst_byte_done", byte_done, 0);
        chk("rst_msg_done", msg_done, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_ready", ready, 1);

        send(1'b1, 4'd3, 7'd60, 7'd100, -100);    // 0x93 3C 64
        send(1'b0, 4'd0, 7'h40, 7'h00, -100);     // 0x80 40 00
        send(1'b1, 4'd5, 7'h45, 7'h33, 45);       // stray req during byte 2
        send(1'b1, 4'd3, 7'd60, 7'd100, -100);
        send(1'b1, 4'd3, 7'd60, 7'd100, -100);    // running status candidate
        send(1'b0, 4'd3, 7'h30, 7'h10, -100);     // 0x83

        // Reset mid-bit during D1
        wait_ready();
        nb = model_push(1'b1, 4'd3, 7'd60, 7'd100);
        drive(1'b1, 4'd3, 7'd60, 7'd100);
        @(posedge clk); #1 req = 1'b0;
        w = 0;
        @(negedge clk);
        while (tx !== 1'b0 && w < 20) begin @(negedge clk); w++; end
        repeat (10 * CPB + 5) @(negedge clk);
        chk("tx_low_before_reset", tx, 0);
        @(posedge clk); #2 rst_n = 1'b0;
        #1;
        chk("tx_async_reset", tx, 1);
        chk("ready_in_reset", ready, 1);
        exp_total -= exp_q.size();
        exp_q.delete();
        m_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1 chk("ready_after_release", ready, 1);
        send(1'b1, 4'd3, 7'd60, 7'd100, -100);    // status resent after reset

        // req held high across three messages
        wait_ready();
        nb  = model_push(1'b1, 4'd7, 7'h11, 7'h22);
        nb += model_push(1'b1, 4'd7, 7'h11, 7'h22);
        nb += model_push(1'b1, 4'd7, 7'h11, 7'h22);
        drive(1'b1, 4'd7, 7'h11, 7'h22);
        mdn = 0; cyc = 0;
        while (mdn < 3 && cyc < 3000) begin
            @(negedge clk); cyc++;
            if (msg_done === 1'b1) begin
                mdn++;
                if (mdn < 3) begin
                    gap = 0;
                    @(negedge clk); cyc++;
                    while (tx === 1'b1 && gap < 10) begin gap++; @(negedge clk); cyc++; end
                    chk("mark_gap", gap, 1);
                    if (mdn == 2) req = 1'b0;
                end
            end
        end
        chk("held_req_msgs", mdn, 3);
        repeat (50) @(negedge clk);
        chk("held_req_idle_ready", ready, 1);
        chk("held_req_idle_tx", tx, 1);
        chk("held_req_queue", exp_q.size(), 0);
        chk("rx_byte_count", rx_cnt, exp_total);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
